// File: rtl/operand_skew_a_pkg.sv
// Shared definitions for the A-side operand path (input line buffer and skew stage).
package operand_skew_a_pkg;

    // Tile sequencing states shared by the buffer and the skew stage
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_t;

    localparam int DEFAULT_ROWS       = 4;
    localparam int DEFAULT_COLS       = 64;
    localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register carrying one operand plus a real-data flag.
// A depth of zero collapses to a straight wire so row 0 needs no special case.
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_flag,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_flag
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, adv};
            assign out_data    = in_data;
            assign out_flag    = in_flag;
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] data_q [DEPTH];
            logic [DEPTH-1:0]      flag_q;

            // Shift the whole chain one step on every advance; reset drops all contents
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                    flag_q <= '0;
                end else if (adv) begin
                    data_q[0] <= in_data;
                    flag_q[0] <= in_flag;
                    for (int i = 1; i < DEPTH; i++) begin
                        data_q[i] <= data_q[i-1];
                        flag_q[i] <= flag_q[i-1];
                    end
                end
            end

            assign out_data = data_q[DEPTH-1];
            assign out_flag = flag_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/operand_skew_a.sv
// Operand skew stage: delays row r by r beats so columns enter the systolic
// array on a diagonal wavefront, then flushes with ROWS-1 zero beats per tile.
module operand_skew_a
    import operand_skew_a_pkg::*;
#(
    parameter int ROWS       = DEFAULT_ROWS,
    parameter int COLS       = DEFAULT_COLS,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic [ROWS-1:0]            out_row_valid,
    output logic                       busy,
    output logic                       tile_done
);

    localparam int CW  = $clog2(COLS) + 1;
    localparam int DCW = $clog2(ROWS) + 1;

    skew_state_t                          state;
    logic [CW-1:0]                        col_cnt;
    logic [DCW-1:0]                       drain_cnt;

    logic                                 accept;
    logic                                 adv;
    logic                                 last_col;
    logic                                 drain_last;
    logic                                 final_adv;
    logic [ROWS*DATA_WIDTH-1:0]           head_data;
    logic                                 head_flag;
    logic [ROWS-1:0][DATA_WIDTH-1:0]      tail_data;
    logic [ROWS-1:0]                      tail_flag;

    // The stage can take a column whenever the output slot is free or emptying,
    // except while flushing the diagonal
    assign in_ready   = (state != DRAIN) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign adv        = (!out_valid || out_ready) && (accept || state == DRAIN);
    assign busy       = (state != IDLE);

    assign last_col   = (state == IDLE && COLS == 1) ||
                        (state == STREAM && int'(col_cnt) == COLS - 1);
    assign drain_last = (int'(drain_cnt) == ROWS - 2);

    // With a single row there is no flush, so the tile ends on its last input beat
    assign final_adv  = (ROWS == 1) ? (accept && last_col)
                                    : (adv && state == DRAIN && drain_last);

    // During the flush the chain heads are fed zero pads instead of upstream data
    assign head_data  = (state == DRAIN) ? '0 : in_data;
    assign head_flag  = (state != DRAIN);

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            skew_delay_line #(
                .DEPTH      (r),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_line (
                .clk      (clk),
                .rst      (rst),
                .adv      (adv),
                .in_data  (head_data[r*DATA_WIDTH +: DATA_WIDTH]),
                .in_flag  (head_flag),
                .out_data (tail_data[r]),
                .out_flag (tail_flag[r])
            );
        end
    endgenerate

    // Tile sequencing: count accepted columns, then count flush beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (COLS == 1) begin
                            col_cnt <= '0;
                            if (ROWS == 1) state <= IDLE;
                            else           state <= DRAIN;
                        end else begin
                            col_cnt <= CW'(1);
                            state   <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (last_col) begin
                            col_cnt <= '0;
                            if (ROWS == 1) state <= IDLE;
                            else           state <= DRAIN;
                        end else begin
                            col_cnt <= col_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (adv) begin
                        if (drain_last) begin
                            drain_cnt <= '0;
                            state     <= IDLE;
                        end else begin
                            drain_cnt <= drain_cnt + DCW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load chain tails on advance, empty on a transfer with
    // nothing behind it, otherwise hold; tile_done rides with the final column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_row_valid <= '0;
            tile_done     <= 1'b0;
        end else if (adv) begin
            out_valid     <= 1'b1;
            out_data      <= tail_data;
            out_row_valid <= tail_flag;
            tile_done     <= final_adv;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
            tile_done     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_skew_a.sv
// Self-checking bench for operand_skew_a: a 4x4 instance against a diagonal
// reference model, a 4x64 instance for long/back-to-back/reset tiles, and a
// single-row instance.
`timescale 1ns/1ps
module tb_operand_skew_a;

    localparam int A_ROWS = 4;
    localparam int A_COLS = 4;
    localparam int DW     = 16;
    localparam int L_ROWS = 4;
    localparam int L_COLS = 64;

    typedef struct packed {
        logic                   done;
        logic [A_ROWS-1:0]      flags;
        logic [A_ROWS*DW-1:0]   data;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: 4 rows, 4 columns
    logic                  a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_tile_done;
    logic [A_ROWS*DW-1:0]  a_in_data, a_out_data;
    logic [A_ROWS-1:0]     a_out_row_valid;

    // Instance L: 4 rows, 64 columns
    logic                  l_rst, l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_busy, l_tile_done;
    logic [L_ROWS*DW-1:0]  l_in_data, l_out_data;
    logic [L_ROWS-1:0]     l_out_row_valid;

    // Instance B: 1 row, 2 columns
    logic                  b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_tile_done;
    logic [DW-1:0]         b_in_data, b_out_data;
    logic [0:0]            b_out_row_valid;

    operand_skew_a #(.ROWS(A_ROWS), .COLS(A_COLS), .DATA_WIDTH(DW)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_row_valid(a_out_row_valid), .busy(a_busy), .tile_done(a_tile_done));

    operand_skew_a #(.ROWS(L_ROWS), .COLS(L_COLS), .DATA_WIDTH(DW)) dut_l (
        .clk(clk), .rst(l_rst), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
        .out_row_valid(l_out_row_valid), .busy(l_busy), .tile_done(l_tile_done));

    operand_skew_a #(.ROWS(1), .COLS(2), .DATA_WIDTH(DW)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_row_valid(b_out_row_valid), .busy(b_busy), .tile_done(b_tile_done));

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // ---------------- Instance A model and stimulus ----------------
    logic [A_ROWS*DW-1:0] a_cols [A_COLS];
    xfer_t                a_exp [$];
    int                   a_xfers = 0;
    int                   a_done  = 0;
    int                   a_ready_mode = 0;

    // Diagonal rule: transfer t carries column t-r on row r when that column exists
    task automatic modelTile();
        for (int t = 0; t < A_COLS + A_ROWS - 1; t++) begin
            xfer_t e;
            e = '0;
            for (int r = 0; r < A_ROWS; r++) begin
                int k;
                k = t - r;
                if (k >= 0 && k < A_COLS) begin
                    e.data[r*DW +: DW] = a_cols[k][r*DW +: DW];
                    e.flags[r]         = 1'b1;
                end
            end
            e.done = (t == A_COLS + A_ROWS - 2);
            a_exp.push_back(e);
        end
    endtask

    // Send the columns in a_cols; bubble_mode 1 idles one cycle between beats, 2 idles randomly
    task automatic applyStimulus(input int bubble_mode, output int first_wait);
        first_wait = 0;
        for (int k = 0; k < A_COLS; k++) begin
            int idle;
            int w;
            idle = 0;
            if (bubble_mode == 1 && k > 0) idle = 1;
            else if (bubble_mode == 2)      idle = int'($urandom_range(0, 2));
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
            a_in_valid = 1'b1;
            a_in_data  = a_cols[k];
            w = 0;
            @(negedge clk);
            while (!a_in_ready && w < 100) begin
                w++;
                @(negedge clk);
            end
            if (w >= 100) checkOutput("a_accept_timeout", 1, 0);
            if (k == 0) first_wait = w;
            @(posedge clk);
            #1;
            a_in_valid = 1'b0;
        end
    endtask

    task automatic waitDrainA();
        int w;
        w = 0;
        while (a_exp.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        #1;
        checkOutput("a_drain_empty", a_exp.size(), 0);
    endtask

    // Downstream ready pattern for instance A
    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (a_ready_mode)
                0:       a_out_ready = 1'b1;
                1:       a_out_ready = !a_out_ready;
                default: a_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Every presented column must match the next expected transfer, stalled or not
    always @(negedge clk) begin
        if (!a_rst && a_out_valid) begin
            if (a_exp.size() == 0) begin
                checkOutput("a_extra_xfer", 1, 0);
            end else begin
                checkOutput("a_xfer", {a_tile_done, a_out_row_valid, a_out_data}, a_exp[0]);
                if (a_out_ready) begin
                    void'(a_exp.pop_front());
                    a_xfers++;
                    if (a_tile_done) a_done++;
                end
            end
        end
    end

    // ---------------- Instance L model and stimulus ----------------
    int l_t     = 0;
    int l_tag   = 1;
    int l_xfers = 0;
    int l_done  = 0;

    function automatic logic [15:0] l_val(input int tag, input int k, input int r);
        return 16'(tag * 4096 + r * 256 + k);
    endfunction

    task automatic applyLongTile(input int tag, input int n_beats, output int first_wait);
        first_wait = 0;
        for (int k = 0; k < n_beats; k++) begin
            int w;
            l_in_valid = 1'b1;
            for (int r = 0; r < L_ROWS; r++) l_in_data[r*DW +: DW] = l_val(tag, k, r);
            w = 0;
            @(negedge clk);
            while (!l_in_ready && w < 100) begin
                w++;
                @(negedge clk);
            end
            if (w >= 100) checkOutput("l_accept_timeout", 1, 0);
            if (k == 0) first_wait = w;
            @(posedge clk);
            #1;
        end
        l_in_valid = 1'b0;
    endtask

    task automatic waitL(input int target);
        int w;
        w = 0;
        while (l_xfers < target && w < 400) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : l_mon
        logic [L_ROWS*DW-1:0] d;
        logic [L_ROWS-1:0]    f;
        int                   k;
        if (!l_rst && l_out_valid && l_out_ready) begin
            d = '0;
            f = '0;
            for (int r = 0; r < L_ROWS; r++) begin
                k = l_t - r;
                if (k >= 0 && k < L_COLS) begin
                    d[r*DW +: DW] = l_val(l_tag, k, r);
                    f[r]          = 1'b1;
                end
            end
            checkOutput("l_xfer", {l_tile_done, l_out_row_valid, l_out_data},
                        {(l_t == L_COLS + L_ROWS - 2), f, d});
            l_xfers++;
            if (l_tile_done) l_done++;
            l_t++;
            if (l_t == L_COLS + L_ROWS - 1) begin
                l_t = 0;
                l_tag++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- Test sequence ----------------
    initial begin
        int fw;
        a_rst = 1'b1; l_rst = 1'b1; b_rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0;
        l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        a_rst = 1'b0; l_rst = 1'b0; b_rst = 1'b0;
        #1;
        checkOutput("rst_in_ready",      a_in_ready, 1);
        checkOutput("rst_out_valid",     a_out_valid, 0);
        checkOutput("rst_out_data",      a_out_data, 0);
        checkOutput("rst_out_row_valid", a_out_row_valid, 0);
        checkOutput("rst_busy",          a_busy, 0);
        checkOutput("rst_tile_done",     a_tile_done, 0);
        checkOutput("rst_b_out_valid",   b_out_valid, 0);
        @(posedge clk);
        #1;

        $display("[TB] single tile, ready high");
        for (int k = 0; k < A_COLS; k++)
            for (int r = 0; r < A_ROWS; r++) a_cols[k][r*DW +: DW] = 16'(r * 16 + k);
        a_xfers = 0; a_done = 0;
        modelTile();
        applyStimulus(0, fw);
        waitDrainA();
        checkOutput("single_xfer_count", a_xfers, 7);
        checkOutput("single_done_count", a_done, 1);

        $display("[TB] single tile, ready toggling");
        a_ready_mode = 1;
        a_xfers = 0; a_done = 0;
        modelTile();
        applyStimulus(0, fw);
        waitDrainA();
        a_ready_mode = 0;
        checkOutput("toggle_xfer_count", a_xfers, 7);
        checkOutput("toggle_done_count", a_done, 1);

        $display("[TB] upstream bubbles");
        for (int k = 0; k < A_COLS; k++) a_cols[k] = {$urandom, $urandom};
        a_xfers = 0;
        modelTile();
        applyStimulus(1, fw);
        waitDrainA();
        checkOutput("bubble_xfer_count", a_xfers, 7);

        $display("[TB] back-to-back tiles");
        a_xfers = 0; a_done = 0;
        for (int k = 0; k < A_COLS; k++) a_cols[k] = {$urandom, $urandom};
        modelTile();
        applyStimulus(0, fw);
        for (int k = 0; k < A_COLS; k++) a_cols[k] = {$urandom, $urandom};
        modelTile();
        applyStimulus(0, fw);
        checkOutput("b2b_drain_wait", fw, A_ROWS - 1);
        waitDrainA();
        checkOutput("b2b_xfer_count", a_xfers, 14);
        checkOutput("b2b_done_count", a_done, 2);

        $display("[TB] random tiles with random stalls and bubbles");
        a_ready_mode = 2;
        a_xfers = 0; a_done = 0;
        for (int tile = 0; tile < 6; tile++) begin
            for (int k = 0; k < A_COLS; k++) a_cols[k] = {$urandom, $urandom};
            modelTile();
            applyStimulus(2, fw);
        end
        waitDrainA();
        a_ready_mode = 0;
        checkOutput("rand_xfer_count", a_xfers, 42);
        checkOutput("rand_done_count", a_done, 6);

        $display("[TB] single-row build");
        b_in_valid = 1'b1;
        b_in_data  = 16'h00A1;
        @(negedge clk);
        checkOutput("b_in_ready", b_in_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("b_first_valid", b_out_valid, 1);
        checkOutput("b_first_data",  {b_tile_done, b_out_row_valid, b_out_data}, {1'b0, 1'b1, 16'h00A1});
        checkOutput("b_first_busy",  b_busy, 1);
        b_in_data = 16'h00B2;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        checkOutput("b_second_data", {b_tile_done, b_out_row_valid, b_out_data}, {1'b1, 1'b1, 16'h00B2});
        checkOutput("b_no_drain",    b_busy, 0);
        checkOutput("b_in_ready_after", b_in_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("b_empty_valid", b_out_valid, 0);
        checkOutput("b_empty_done",  b_tile_done, 0);

        $display("[TB] long back-to-back tiles");
        l_xfers = 0; l_done = 0;
        applyLongTile(1, L_COLS, fw);
        applyLongTile(2, L_COLS, fw);
        checkOutput("l_b2b_drain_wait", fw, L_ROWS - 1);
        waitL(134);
        checkOutput("l_b2b_xfer_count", l_xfers, 134);
        checkOutput("l_b2b_done_count", l_done, 2);

        $display("[TB] reset mid-tile");
        applyLongTile(3, 30, fw);
        l_in_valid = 1'b1;
        for (int r = 0; r < L_ROWS; r++) l_in_data[r*DW +: DW] = l_val(3, 30, r);
        #2;
        checkOutput("l_busy_pre_rst", l_busy, 1);
        l_rst = 1'b1;
        #1;
        checkOutput("l_rst_out_valid",     l_out_valid, 0);
        checkOutput("l_rst_out_row_valid", l_out_row_valid, 0);
        checkOutput("l_rst_busy",          l_busy, 0);
        checkOutput("l_rst_tile_done",     l_tile_done, 0);
        l_in_valid = 1'b0;
        l_t = 0; l_tag = 4; l_xfers = 0; l_done = 0;
        @(posedge clk);
        #3;
        l_rst = 1'b0;
        @(posedge clk);
        #1;
        applyLongTile(4, L_COLS, fw);
        waitL(67);
        checkOutput("l_clean_xfer_count", l_xfers, 67);
        checkOutput("l_clean_done_count", l_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_skew_a.md
# operand_skew_a

Operand skew stage sitting directly downstream of the A-side input line buffer and upstream of the systolic array's west edge. It accepts one column of ROWS operands per beat. It delays row r by r beats so the values enter the array on a diagonal wavefront, and pads the unused slots with zeros. After each COLS-beat tile it flushes the skew pipeline with ROWS-1 zero beats so the last diagonal leaves cleanly.

## Interface
- ROWS, 4, operand rows (array height); must be at least 1
- COLS, 64, beats per tile
- DATA_WIDTH, 16, operand width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_valid  in  1  upstream column valid
- in_ready  out  1  stage can accept a column
- in_data  in  ROWS*DATA_WIDTH  row r at bits [r*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  skewed column valid
- out_ready  in  1  array accepts a column
- out_data  out  ROWS*DATA_WIDTH  skewed column, same packing
- out_row_valid  out  ROWS  bit r = row r carries real data (0 = pad)
- busy  out  1  state != IDLE
- tile_done  out  1  one-cycle pulse on the final drain transfer

## Operation
- Row r has an r-deep delay chain followed by one output register. Each chain entry carries data plus a valid flag.
- adv = (!out_valid || out_ready) && (in_valid && in_ready || state == DRAIN).
- On adv:
  - Every chain shifts one step.
  - Chain heads load in_data with flag 1 in IDLE/STREAM, or 0 data with flag 0 in DRAIN.
  - Output registers load the chain tails. Row 0 loads in_data directly.
  - out_valid <= 1.
- No adv and out_ready high: out_valid <= 0. Data and flags hold.
- No adv and out_ready low: everything holds.
- out_row_valid[r] is the flag of the row r output register. Pad slots always present data 0.
- FSM:
  - IDLE: in_ready = !out_valid || out_ready. An accepted beat sets col_cnt to 1 and moves to STREAM, or to DRAIN if COLS == 1.
  - STREAM: same in_ready rule. Each accepted beat increments col_cnt. The beat accepted at col_cnt == COLS-1 moves to DRAIN (or to IDLE when ROWS == 1) and clears col_cnt.
  - DRAIN: in_ready = 0. Each adv increments drain_cnt. The adv at drain_cnt == ROWS-2 moves to IDLE, clears drain_cnt and pulses tile_done.
- When ROWS == 1, tile_done pulses on the last input beat.
- col_cnt is $clog2(COLS)+1 bits; drain_cnt is $clog2(ROWS)+1 bits; both are unsigned and never wrap mid-tile.
- in_valid while in_ready is low is ignored. Upstream must hold the beat.

## Timing
- Reset values:
  - in_ready 1 (output empty)
  - out_valid 0
  - out_data 0
  - out_row_valid 0
  - busy 0
  - tile_done 0
  - state IDLE
  - all chains and counters 0
- Latency: input beat k of row r appears at the output register after r+1 advances.
- With no stalls, row r element k is presented r+1 cycles after acceptance.
- A tile takes COLS + ROWS - 1 output transfers, with no bubbles if upstream and downstream never stall.
- Back-to-back tiles: the first beat of the next tile may be accepted in the cycle after the tile_done transfer (IDLE). It is never accepted during DRAIN.
- Asynchronous rst mid-tile discards all chain contents immediately. No tile_done is emitted for the aborted tile.
- in_ready is combinational from out_valid/out_ready/state. No other output depends combinationally on inputs.

## Structure
- Shared package (same as the input buffer):
  - skew_state_t enum {IDLE, STREAM, DRAIN}
  - default ROWS/COLS/DATA_WIDTH constants
- One sub-module: skew_delay_line (parameters DEPTH, DATA_WIDTH; ports clk, rst, adv, in data/flag, out data/flag).
  - Instantiate per row with DEPTH = r via a generate loop.
  - DEPTH = 0 is a pure wire.
- The FSM, counters and output register live in the top module.

## Test plan
- Reset then single tile, ROWS=4, COLS=4, in_data rows = {r*16+k}, out_ready constantly 1. Required response:
  - 7 transfers
  - transfer t has row r = r*16+(t-r) where 0 ≤ t-r < 4, else 0 with out_row_valid[r] = 0
  - tile_done on transfer 7
- Same tile with out_ready toggled 1-0-1-0. Required response: identical transfer sequence; out_data stable while out_valid && !out_ready.
- Upstream bubbles (in_valid low every other cycle) in STREAM. Required response: no duplicate transfers; out_valid drops during bubbles once drained; ordering preserved.
- Two tiles back-to-back, COLS=64. Required response:
  - in_ready low for exactly 3 DRAIN adv cycles between tiles
  - 134 transfers total
  - two tile_done pulses
- Assert rst during beat 30 of a tile. Required response:
  - out_valid, out_row_valid and busy go to 0 asynchronously
  - the next tile starts clean with no stale data
- ROWS=1, COLS=2 build. Required response: no DRAIN state entered; tile_done on the second input transfer; latency 1.
